// File: rtl/conv_cmd_scheduler_if.sv
// Command/response and engine-side signal bundle for conv_cmd_scheduler.
// The slave modport is the scheduler; the master modport is the CPU plus conv engine.
interface conv_cmd_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_funct7;
  logic [31:0] cmd_in0;
  logic [31:0] cmd_in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        eng_en;
  logic [6:0]  eng_cmd;
  logic [31:0] eng_in0;
  logic [31:0] eng_in1;
  logic [31:0] eng_ret;
  logic        eng_done;

  modport slave (
    input  cmd_valid, cmd_funct7, cmd_in0, cmd_in1, rsp_ready, eng_ret, eng_done,
    output cmd_ready, rsp_valid, rsp_data, eng_en, eng_cmd, eng_in0, eng_in1
  );

  modport master (
    output cmd_valid, cmd_funct7, cmd_in0, cmd_in1, rsp_ready, eng_ret, eng_done,
    input  cmd_ready, rsp_valid, rsp_data, eng_en, eng_cmd, eng_in0, eng_in1
  );
endinterface

// File: rtl/conv_cmd_scheduler.sv
// Schedules CPU commands onto the conv engine with a per-command timeout,
// and serves local status-read / counter-clear commands without touching the engine.
module conv_cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [6:0]  STATUS_FUNCT7  = 7'h7F,
  parameter logic [6:0]  CLEAR_FUNCT7   = 7'h7E
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_cmd_scheduler_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_rsp_data;
  logic [6:0]    r_eng_cmd;
  logic [31:0]   r_eng_in0;
  logic [31:0]   r_eng_in1;
  logic          r_err_sticky;
  logic [14:0]   r_timeout_count;
  logic [15:0]   r_done_count;

  logic w_is_status;
  logic w_is_clear;
  logic w_busy;
  logic w_timeout;

  assign w_is_status = (bus.cmd_funct7 == STATUS_FUNCT7);
  assign w_is_clear  = (bus.cmd_funct7 == CLEAR_FUNCT7);
  assign w_busy      = (r_state == ISSUE) || (r_state == WAIT);
  assign w_timeout   = w_busy && (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (bus.cmd_valid) w_state_next = (w_is_status || w_is_clear) ? RESP : ISSUE;
      ISSUE: w_state_next = (bus.eng_done || w_timeout) ? RESP : WAIT;
      WAIT:  if (bus.eng_done || w_timeout) w_state_next = RESP;
      RESP:  if (bus.rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Completion is checked before timeout so a done on the last allowed cycle still counts as success.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer         <= '0;
      r_rsp_data      <= '0;
      r_eng_cmd       <= '0;
      r_eng_in0       <= '0;
      r_eng_in1       <= '0;
      r_err_sticky    <= 1'b0;
      r_timeout_count <= '0;
      r_done_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (w_is_status) begin
              r_rsp_data <= {r_err_sticky, r_timeout_count, r_done_count};
            end else if (w_is_clear) begin
              r_rsp_data      <= '0;
              r_err_sticky    <= 1'b0;
              r_timeout_count <= '0;
              r_done_count    <= '0;
            end else begin
              r_eng_cmd <= bus.cmd_funct7;
              r_eng_in0 <= bus.cmd_in0;
              r_eng_in1 <= bus.cmd_in1;
              r_timer   <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (bus.eng_done) begin
            r_rsp_data   <= bus.eng_ret;
            r_done_count <= r_done_count + 16'd1;
          end else if (w_timeout) begin
            r_rsp_data   <= '1;
            r_err_sticky <= 1'b1;
            if (r_timeout_count != '1) r_timeout_count <= r_timeout_count + 15'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.eng_en    = w_busy;
  assign bus.eng_cmd   = r_eng_cmd;
  assign bus.eng_in0   = r_eng_in0;
  assign bus.eng_in1   = r_eng_in1;

endmodule

// File: doc/conv_cmd_scheduler.md
CONV_CMD_SCHEDULER -- requirements
Module: conv_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum engine cycles per command before abort.
REQ-002 The block SHALL have parameter STATUS_FUNCT7, default 7'h7F, selecting the local status-read command.
REQ-003 The block SHALL have parameter CLEAR_FUNCT7, default 7'h7E, selecting the local counter-clear command.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  CPU command request.
REQ-007 cmd_ready  out  1  scheduler accepts a command this cycle.
REQ-008 cmd_funct7  in  7  command opcode.
REQ-009 cmd_in0, cmd_in1  in  32 each  command operands.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  CPU consumes the response.
REQ-012 rsp_data  out  32  response word, registered.
REQ-013 eng_en  out  1  conv engine enable.
REQ-014 eng_cmd  out  7; eng_in0, eng_in1  out  32 each  captured opcode and operands driven to the engine.
REQ-015 eng_ret  in  32; eng_done  in  1  engine result and result-valid.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018 Engine command accept: IDLE with cmd_valid and funct7 not STATUS/CLEAR -> capture funct7/in0/in1 into eng_cmd/eng_in0/eng_in1, go ISSUE.
REQ-019 eng_en SHALL be 1 in ISSUE and WAIT and 0 otherwise, with eng_cmd/eng_in0/eng_in1 held stable throughout.
REQ-020 Completion: in ISSUE or WAIT with eng_done=1 -> rsp_data<=eng_ret, done_count+1 (16-bit, wraps), go RESP.
REQ-021 No completion: ISSUE with eng_done=0 -> WAIT.
REQ-022 eng_done SHALL be ignored in IDLE and RESP.
REQ-023 Minimum latency: accept at edge N, eng_en high during cycle N+1, eng_done in that cycle, rsp_valid high from edge N+2.
REQ-024 Timeout counter: cleared on accept, +1 per cycle in ISSUE/WAIT.
REQ-025 On timeout (counter reaches TIMEOUT_CYCLES-1 with eng_done=0): rsp_data<=32'hFFFF_FFFF, err_sticky<=1, timeout_count+1 (15-bit, saturates at 7FFF), go RESP.
REQ-026 If eng_done and timeout coincide, completion SHALL win.
REQ-027 STATUS in IDLE -> RESP next cycle with rsp_data={err_sticky, timeout_count[14:0], done_count[15:0]}, engine untouched.
REQ-028 CLEAR in IDLE -> err_sticky, timeout_count and done_count <=0, rsp_data<=0, go RESP, engine untouched.
REQ-029 RESP: rsp_data held stable; rsp_ready=1 -> IDLE, otherwise stay.
REQ-030 Back-to-back: a new command SHALL NOT be accepted in the cycle rsp_ready is sampled, so there is at least 1 IDLE cycle between responses.

Reset
REQ-031 On reset: state=IDLE; rsp_valid, eng_en and rsp_data =0; eng_cmd/eng_in0/eng_in1 =0; all counters and err_sticky =0.
REQ-032 Reset mid-command SHALL abandon it: eng_en=0 from the edge where reset is sampled, no response issued, no counter updated.

Verification
REQ-033 cmd funct7=3, in0=5, in1=7; eng_done=1 in first eng_en cycle with eng_ret=0x0000_0023 -> rsp_valid at accept+2 edges, rsp_data=0x23; STATUS then returns 0x0000_0001.
REQ-034 eng_done held 0, TIMEOUT_CYCLES=16 -> eng_en high exactly 16 cycles, rsp_data=0xFFFF_FFFF; STATUS returns 0x8001_0000.
REQ-035 Response stalled: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, new cmd_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-036 CLEAR after REQ-034 -> rsp_data=0; following STATUS returns 0x0000_0000.
REQ-037 Reset asserted during WAIT -> eng_en=0 and rsp_valid=0 after that edge; late eng_done=1 produces no response; STATUS afterwards returns 0.
REQ-038 eng_done=1 on the timeout cycle -> rsp_data=eng_ret, err_sticky stays 0.
